// File: rtl/serial_add_pkg.sv
// Shared types and defaults for the serial-add sequencer slice.
package serial_add_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} sas_state_t;

    localparam int SAS_DEFAULT_W = 8;

endpackage

// File: rtl/serial_add_sequencer_if.sv
// Operand and result valid/ready handshakes for the serial-add sequencer.
interface serial_add_sequencer_if
    import serial_add_pkg::*;
#(
    parameter int W = SAS_DEFAULT_W
);

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_carry;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_sum, out_carry
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_sum, out_carry
    );

endinterface

// File: rtl/serial_add_core.sv
// One-bit full adder with a registered carry; the carry is the only state.
module serial_add_core
    import serial_add_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);

    logic carry_d;

    assign sum     = a ^ b ^ carry;
    assign carry_d = (a & b) | (a & carry) | (b & carry);

    // Clear wins over advance so a fresh operation never inherits a stale carry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry <= 1'b0;
        end else if (clr) begin
            carry <= 1'b0;
        end else if (en) begin
            carry <= carry_d;
        end
    end

endmodule

// File: rtl/serial_add_sequencer.sv
// Feeds parallel operands LSB-first through the serial adder core and
// collects the W-bit sum plus carry-out behind valid/ready handshakes.
module serial_add_sequencer
    import serial_add_pkg::*;
#(
    parameter int W = SAS_DEFAULT_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    serial_add_sequencer_if.slave  bus
);

    localparam int CNT_W = $clog2(W + 1);

    sas_state_t       state;
    sas_state_t       state_nxt;
    logic [W-1:0]     a_sh;
    logic [W-1:0]     b_sh;
    logic [W-1:0]     res;
    logic [W:0]       res_cat;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             run_en;
    logic             last_bit;
    logic             core_sum;
    logic             core_carry;

    serial_add_core u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept),
        .en    (run_en),
        .a     (a_sh[0]),
        .b     (b_sh[0]),
        .sum   (core_sum),
        .carry (core_carry)
    );

    assign last_bit = (cnt == CNT_W'(W - 1));

    // Concatenate then shift so the new sum bit lands in res[W-1]; works for W=1 too.
    assign res_cat = {core_sum, res} >> 1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        accept        = 1'b0;
        run_en        = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                run_en = 1'b1;
                if (last_bit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh <= '0;
            b_sh <= '0;
            res  <= '0;
            cnt  <= '0;
        end else if (accept) begin
            a_sh <= bus.in_a;
            b_sh <= bus.in_b;
            res  <= '0;
            cnt  <= '0;
        end else if (run_en) begin
            a_sh <= a_sh >> 1;
            b_sh <= b_sh >> 1;
            res  <= res_cat[W-1:0];
            cnt  <= cnt + CNT_W'(1);
        end
    end

    // Result is only exposed while it is valid, so outputs read zero otherwise.
    assign bus.out_sum   = bus.out_valid ? res : '0;
    assign bus.out_carry = bus.out_valid & core_carry;

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Directed table, hand-written corner sequences and a random sweep for the
// serial-add sequencer at W=8, plus a small W=1 instance.
module tb_serial_add_sequencer;
    import serial_add_pkg::*;

    localparam int W = 8;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] sum;
        logic       carry;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    serial_add_sequencer_if #(.W(W)) bus ();
    serial_add_sequencer_if #(.W(1)) bus1 ();

    serial_add_sequencer #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    serial_add_sequencer #(.W(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Offers one operand pair, returns once the result is valid (or the bound expires).
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                                 output logic [7:0] sum, output logic carry, output int lat);
        @(negedge clk);
        checkOutput("in_ready before offer", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        sum   = bus.out_sum;
        carry = bus.out_carry;
    endtask

    task automatic takeResult();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        vec_t       vecs [8];
        logic [7:0] s;
        logic       c;
        int         lat;
        int         accepts;
        int         first_acc;
        int         last_acc;
        int         second_acc;
        logic [8:0] model;
        logic [7:0] ra;
        logic [7:0] rb;

        vecs[0] = '{8'h5A, 8'h33, 8'h8D, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 8'h00, 1'b1};
        vecs[2] = '{8'h00, 8'h00, 8'h00, 1'b0};
        vecs[3] = '{8'hFF, 8'hFF, 8'hFE, 1'b1};
        vecs[4] = '{8'h10, 8'h20, 8'h30, 1'b0};
        vecs[5] = '{8'h80, 8'h80, 8'h00, 1'b1};
        vecs[6] = '{8'h0F, 8'hF1, 8'h00, 1'b1};
        vecs[7] = '{8'h7F, 8'h01, 8'h80, 1'b0};

        rst_n          = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_a       = '0;
        bus.in_b       = '0;
        bus.out_ready  = 1'b0;
        bus1.in_valid  = 1'b0;
        bus1.in_a      = '0;
        bus1.in_b      = '0;
        bus1.out_ready = 1'b0;

        #12;
        checkOutput("reset in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("reset out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("reset out_sum", 32'(bus.out_sum), 32'd0);
        checkOutput("reset out_carry", 32'(bus.out_carry), 32'd0);
        checkOutput("reset w1 in_ready", 32'(bus1.in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] directed table");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, s, c, lat);
            checkOutput($sformatf("vec%0d sum", i), 32'(s), 32'(vecs[i].sum));
            checkOutput($sformatf("vec%0d carry", i), 32'(c), 32'(vecs[i].carry));
            checkOutput($sformatf("vec%0d latency", i), 32'(lat), 32'(W));
            takeResult();
        end

        $display("[TB] back-pressure");
        applyStimulus(8'hFF, 8'hFF, s, c, lat);
        bus.in_valid = 1'b1;
        bus.in_a     = 8'h11;
        bus.in_b     = 8'h22;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput($sformatf("hold%0d out_valid", i), 32'(bus.out_valid), 32'd1);
            checkOutput($sformatf("hold%0d out_sum", i), 32'(bus.out_sum), 32'hFE);
            checkOutput($sformatf("hold%0d out_carry", i), 32'(bus.out_carry), 32'd1);
            checkOutput($sformatf("hold%0d in_ready", i), 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid = 1'b0;
        takeResult();
        checkOutput("after hold in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("after hold out_valid", 32'(bus.out_valid), 32'd0);

        $display("[TB] reset mid-run");
        bus.in_valid = 1'b1;
        bus.in_a     = 8'h5A;
        bus.in_b     = 8'h33;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("midrst out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("midrst out_sum", 32'(bus.out_sum), 32'd0);
        checkOutput("midrst out_carry", 32'(bus.out_carry), 32'd0);
        checkOutput("midrst counter", 32'(dut.cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(8'h10, 8'h20, s, c, lat);
        checkOutput("post rst sum", 32'(s), 32'h30);
        checkOutput("post rst carry", 32'(c), 32'd0);
        checkOutput("post rst latency", 32'(lat), 32'(W));
        takeResult();

        $display("[TB] issue period");
        bus.in_a      = 8'h01;
        bus.in_b      = 8'h02;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        accepts    = 0;
        first_acc  = -1;
        second_acc = -1;
        last_acc   = -1;
        for (int cyc = 0; cyc < 31; cyc++) begin
            if (bus.in_valid && bus.in_ready) begin
                if (accepts == 0) first_acc = cyc;
                if (accepts == 1) second_acc = cyc;
                last_acc = cyc;
                accepts++;
            end
            if (bus.out_valid) begin
                checkOutput($sformatf("stream sum c%0d", cyc), 32'(bus.out_sum), 32'h03);
            end
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        checkOutput("stream accepts", 32'(accepts), 32'd4);
        checkOutput("stream first", 32'(first_acc), 32'd0);
        checkOutput("stream period", 32'(second_acc - first_acc), 32'(W + 2));
        checkOutput("stream last", 32'(last_acc), 32'd30);
        repeat (12) @(negedge clk);
        bus.out_ready = 1'b0;
        checkOutput("stream drained in_ready", 32'(bus.in_ready), 32'd1);

        $display("[TB] random sweep");
        for (int i = 0; i < 1000; i++) begin
            ra    = 8'($urandom);
            rb    = 8'($urandom);
            model = {1'b0, ra} + {1'b0, rb};
            applyStimulus(ra, rb, s, c, lat);
            checkOutput($sformatf("rnd%0d sum", i), 32'(s), 32'(model[7:0]));
            checkOutput($sformatf("rnd%0d carry", i), 32'(c), 32'(model[8]));
            takeResult();
        end

        $display("[TB] W=1 instance");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus1.in_valid = 1'b1;
            bus1.in_a     = 1'(i >> 1);
            bus1.in_b     = 1'(i);
            @(negedge clk);
            bus1.in_valid = 1'b0;
            lat = 0;
            while (!bus1.out_valid && lat < 20) begin
                @(negedge clk);
                lat++;
            end
            checkOutput($sformatf("w1 case%0d latency", i), 32'(lat), 32'd1);
            checkOutput($sformatf("w1 case%0d sum", i), 32'(bus1.out_sum), 32'((i >> 1) ^ (i & 1)));
            checkOutput($sformatf("w1 case%0d carry", i), 32'(bus1.out_carry), 32'((i >> 1) & i & 1));
            bus1.out_ready = 1'b1;
            @(negedge clk);
            bus1.out_ready = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
